// File: rtl/permutation_ctrl.sv
// Round sequencer for the Ascon permutation: issues rounds 12-N..11, one per clock.
// Optional ASCON_PERM_ABORT_EN adds abort_i to cancel a running permutation.
module permutation_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       ready_o,
  output logic       busy_o,
  output logic       select_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t     r_state;
  logic [3:0] r_round;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_abort;
  logic [3:0] w_start;

  assign w_accept = (r_state != RUN) && start_i;
  assign w_start  = mode_i ? START_B : START_A;

`ifdef ASCON_PERM_ABORT_EN
  assign w_abort = (r_state == RUN) && abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Mealy datapath controls: the acceptance cycle itself loads the external state as round S.
  always_comb begin
    enable_o = 1'b0;
    select_o = 1'b0;
    round_o  = 4'd0;
    if (w_accept) begin
      enable_o = 1'b1;
      round_o  = w_start;
    end else if (r_state == RUN) begin
      enable_o = ~w_abort;
      select_o = 1'b1;
      round_o  = r_round;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_round <= 4'd0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= RUN;
        r_round <= w_start + 4'd1;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state == RUN) begin
        // Abort outranks the final-round transition so no done pulse escapes.
        if (w_abort) begin
          r_state <= IDLE;
          r_round <= 4'd0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end else if (r_round == LAST_ROUND) begin
          r_state <= DONE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_round <= r_round + 4'd1;
        end
      end else begin
        r_state <= IDLE;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: doc/permutation_ctrl.md
# permutation_ctrl

Round-sequencing controller for the Ascon permutation datapath. It sits directly upstream of the permutation stage and drives that stage's input mux select, state-register enable and 4-bit round index. Each accepted request runs one p^a (12 rounds) or p^b (6 rounds) permutation at one round per clock. Completion is reported by a one-cycle done pulse aligned with valid permutation output.

## Interface
- ROUNDS_A, default 12: rounds for p^a; legal 2..12.
- ROUNDS_B, default 6: rounds for p^b; legal 2..12.
- clock_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  permutation request; accepted only while ready_o=1.
- mode_i  in  1  0 = p^a, 1 = p^b; sampled in the acceptance cycle only.
- ready_o  out  1  high when a request can be accepted (IDLE or DONE).
- busy_o  out  1  high in RUN.
- select_o  out  1  permutation mux select: 0 = external state, 1 = register feedback.
- enable_o  out  1  permutation state-register enable.
- round_o  out  4  round index to the constant-addition layer.
- done_o  out  1  one-cycle pulse; permutation output valid this cycle.
- abort_i  in  1  present only with ASCON_PERM_ABORT_EN (see Configuration).

## Operation
- States: IDLE, RUN, DONE; 4-bit round counter round_q.
- N = ROUNDS_A (mode 0) or ROUNDS_B (mode 1). First round index S = 12 - N, so rounds S..11 are issued and the last round is always 11.
- Acceptance happens in IDLE or DONE with start_i=1. Outputs are Mealy in that cycle:
  - enable_o=1, select_o=0, round_o=S.
  - Next state: round_q <= S+1, state <= RUN.
- RUN:
  - enable_o=1, select_o=1, round_o=round_q.
  - If round_q==11, state <= DONE; else round_q <= round_q+1.
- DONE lasts one cycle:
  - done_o=1, ready_o=1.
  - With start_i=1 it accepts a new request exactly as IDLE does. Otherwise state <= IDLE.
- IDLE/DONE without start: enable_o=0, select_o=0, round_o=0.
- start_i in RUN is ignored: no queuing, no effect on the counter.
- round_q never exceeds 11; no wrap-around path exists.
- The controller never touches permutation data. The permutation register holds its value after enable_o falls, until the next acceptance.

## Timing
- Reset values: state IDLE, round_q=0, ready_o=1, busy_o=0, enable_o=0, select_o=0, round_o=0, done_o=0.
- Reset asserted mid-RUN forces IDLE immediately (asynchronously). No done_o is produced.
- Cycle 0 = acceptance cycle. Rounds are registered at the edges ending cycles 0..N-1.
- done_o=1 in cycle N; permutation output is valid from cycle N.
- Throughput: one permutation every N cycles with back-to-back starts issued in DONE.
- ready_o and busy_o are registered state decodes. enable_o, select_o and round_o are combinational from state and start_i. Upstream must hold the external state stable in cycle 0 only.

## Configuration
- ASCON_PERM_ABORT_EN defined:
  - Adds input abort_i.
  - In RUN, abort_i=1 forces enable_o=0 that cycle and state <= IDLE; no done_o follows.
  - Abort takes priority over the round-11 transition to DONE.
  - abort_i is ignored in IDLE and DONE, so start wins there.
- ASCON_PERM_ABORT_EN undefined: port is absent, and every accepted permutation runs to completion.

## Test plan
- Reset: reset_i pulsed in RUN at round_o=5 → same cycle ready_o=1, enable_o=0, round_o=0; done_o stays 0.
- p^a: start_i=1, mode_i=0 in cycle 0 → enable_o=1 in cycles 0..11, select_o=0 only in cycle 0, round_o 0..11, done_o in cycle 12 only. With the permutation attached, the output matches the golden p12 of the Ascon-128 initial state.
- p^b: start_i=1, mode_i=1 → round_o 6..11 in cycles 0..5, done_o in cycle 6, output matches golden p6.
- Back-to-back: p^a start in cycle 0, then start_i=1, mode_i=1 in cycle 12 (DONE) → cycle 12 shows done_o=1, select_o=0, round_o=6; second done_o in cycle 18; enable_o never drops.
- Start while busy: extra start_i=1 in cycle 3 of a p^a run → no effect; single done_o in cycle 12.
- Abort (ASCON_PERM_ABORT_EN): abort_i=1 in cycle 4 of p^a → enable_o=0 in cycle 4, ready_o=1 in cycle 5, no done_o, register holds its round-3 result.
